dds_sweep_ctrl: RTL and testbench
=================================

// Module: dds_sweep_ctrl
// PURPOSE
//  Frequency-sweep scheduler for the DDS phase accumulator. Produces the frequency
//  word K and phase offset P consumed by the DDS core. Steps K linearly from a start
//  word to a stop word, holding each point for a programmable dwell time.
//  Configuration is taken over a valid/ready handshake; the sweep runs on start/abort.
// PARAMETERS
//  KW       32   frequency word width
//  PW       11   phase offset width
//  DWELL_W  16   dwell counter width
// PORTS
//  clk          in   1        system clock, all logic on posedge
//  rst          in   1        asynchronous reset, active-high
//  cfg_valid    in   1        config word valid
//  cfg_ready    out  1        config accepted when cfg_valid & cfg_ready
//  cfg_k_start  in   KW       first sweep frequency word
//  cfg_k_stop   in   KW       last sweep frequency word
//  cfg_k_step   in   KW       increment per point
//  cfg_dwell    in   DWELL_W  dwell count d
//  cfg_p        in   PW       phase offset for the sweep
//  cfg_loop     in   1        1 = restart at k_start after k_stop
//  start        in   1        begin sweep (sampled in IDLE only)
//  abort        in   1        stop sweep immediately
//  K            out  KW       frequency word to DDS (registered)
//  P            out  PW       phase offset to DDS (registered)
//  k_upd        out  1        1-cycle pulse, K/P changed at the preceding edge
//  busy         out  1        sweep in progress (state != IDLE)
//  done         out  1        1-cycle pulse, sweep completed normally
// BEHAVIOUR
//  - Reset: state IDLE, K=0, P=0, k_upd=0, done=0, busy=0, all shadow cfg regs 0.
//    cfg_ready=1 out of reset. Reset mid-sweep aborts with no done pulse.
//  - cfg_ready = (state==IDLE). On the handshake, all cfg_* go into shadow regs.
//    cfg_valid while busy is not accepted and does not disturb the sweep.
//  - States: IDLE -> DWELL -> STEP -> DWELL ... -> IDLE.
//  - IDLE & start (start takes priority over a same-cycle cfg handshake, which still completes):
//    - K<=k_start, P<=cfg_p, dwell cnt<=d, go to DWELL.
//    - k_upd=1 on the next cycle.
//  - DWELL: when cnt==0 go to STEP, else cnt--.
//  - STEP:
//    - K==k_stop & !loop: go to IDLE, pulse done; K/P held.
//    - K==k_stop & loop: K<=k_start, k_upd, reload cnt, go to DWELL.
//    - Otherwise: next = {1'b0,K} + step (KW+1 bits); K <= (next > k_stop) ? k_stop : next.
//      Then k_upd, reload cnt, go to DWELL.
//  - Timing: consecutive k_upd pulses are exactly d+2 cycles apart. done asserts
//    d+2 cycles after the last k_upd.
//  - k_start >= k_stop: single point at k_start, then done (or loop); no downward step.
//  - step == 0 with k_start < k_stop: step treated as 1 (no stall).
//  - No wrap-around: the KW+1-bit sum clamps at k_stop.
//  - abort (any state != IDLE): go to IDLE next edge, K/P held, no done, no k_upd.
//    abort in IDLE has no effect. abort beats start in the same cycle.
//  - start while busy is ignored.
// CONFIGURATION
//  DDS_SWEEP_BIDIR_EN defined:
//    - Adds input cfg_bidir (1 bit) and a direction register (up after start).
//    - bidir=1: on reaching k_stop, reverse and step down, clamping at k_start.
//    - On reaching k_start: loop=1 reverses up again; loop=0 ends with done.
//    - bidir=0: behaves as undefined build.
//  Undefined: up-only sweep; cfg_bidir port absent.
// TESTING
//  - Basic sweep: start=100, stop=130, step=10, d=2, loop=0.
//    -> K=100,110,120,130, k_upd every 4 cycles; done 4 cycles after K=130; busy low after.
//  - Clamp: start=0, stop=25, step=10, d=0 -> K=0,10,20,25 at 2-cycle spacing, then done.
//  - Overflow: start=0xFFFFFFF0, stop=0xFFFFFFFF, step=0x20.
//    -> K=0xFFFFFFF0 then 0xFFFFFFFF, never wraps to a small value.
//  - Loop and abort: start=100, stop=120, step=10, loop=1 -> after 120, K=100 again.
//    abort in DWELL -> busy=0 next cycle, K held, no done; cfg_ready=1.
//  - Handshake/reset: cfg_valid while busy -> not accepted, sweep unchanged.
//    rst asserted mid-sweep -> K=0, P=0, IDLE immediately.
//  - BIDIR build: start=10, stop=30, step=10, bidir=1, loop=0 -> K=10,20,30,20,10, then done.

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep scheduler that drives K (frequency word) and P (phase offset) into the DDS core.
// Define DDS_SWEEP_BIDIR_EN to add cfg_bidir and up/down (triangle) sweeping.
module dds_sweep_ctrl #(
  parameter int KW      = 32,
  parameter int PW      = 11,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [KW-1:0]      cfg_k_start,
  input  logic [KW-1:0]      cfg_k_stop,
  input  logic [KW-1:0]      cfg_k_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [PW-1:0]      cfg_p,
  input  logic               cfg_loop,
`ifdef DDS_SWEEP_BIDIR_EN
  input  logic               cfg_bidir,
`endif
  input  logic               start,
  input  logic               abort,
  output logic [KW-1:0]      K,
  output logic [PW-1:0]      P,
  output logic               k_upd,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, DWELL, STEP} state_t;

  state_t             state;
  logic [KW-1:0]      k_start_s, k_stop_s, k_step_s;
  logic [DWELL_W-1:0] dwell_s, cnt;
  logic [PW-1:0]      p_s;
  logic               loop_s;
  logic               hs;

  logic [KW-1:0]      step_eff;
  logic [KW:0]        up_sum;
  logic [KW-1:0]      up_next;
  logic               at_top;
  logic [KW-1:0]      k_next;
  logic               finish;

  // When start coincides with a config handshake, the freshly accepted values seed the sweep.
  logic [KW-1:0]      st_k;
  logic [PW-1:0]      st_p;
  logic [DWELL_W-1:0] st_d;

`ifdef DDS_SWEEP_BIDIR_EN
  logic               bidir_s, dir_dn, dir_next, at_bot;
  logic [KW:0]        dn_diff;
  logic [KW-1:0]      dn_next;
`endif

  assign cfg_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign hs        = cfg_valid & cfg_ready;

  assign st_k = hs ? cfg_k_start : k_start_s;
  assign st_p = hs ? cfg_p       : p_s;
  assign st_d = hs ? cfg_dwell   : dwell_s;

  // Zero step would stall the sweep; the KW+1-bit sum clamps instead of wrapping.
  assign step_eff = (k_step_s == '0) ? KW'(1) : k_step_s;
  assign up_sum   = {1'b0, K} + {1'b0, step_eff};
  assign up_next  = (up_sum > {1'b0, k_stop_s}) ? k_stop_s : up_sum[KW-1:0];
  assign at_top   = (K >= k_stop_s);

`ifdef DDS_SWEEP_BIDIR_EN
  assign dn_diff = {1'b0, K} - {1'b0, step_eff};
  assign dn_next = (dn_diff[KW] || (dn_diff[KW-1:0] < k_start_s)) ? k_start_s : dn_diff[KW-1:0];
  assign at_bot  = (K <= k_start_s);
`endif

  always_comb begin
    k_next = up_next;
    finish = 1'b0;
`ifdef DDS_SWEEP_BIDIR_EN
    dir_next = dir_dn;
    if (bidir_s) begin
      if (!dir_dn) begin
        if (at_top) begin
          if (!at_bot) begin
            dir_next = 1'b1;
            k_next   = dn_next;
          end else if (loop_s) begin
            k_next = k_start_s;
          end else begin
            finish = 1'b1;
          end
        end
      end else if (at_bot) begin
        if (loop_s) begin
          dir_next = 1'b0;
          k_next   = up_next;
        end else begin
          finish = 1'b1;
        end
      end else begin
        k_next = dn_next;
      end
    end else if (at_top) begin
      if (loop_s) k_next = k_start_s;
      else        finish = 1'b1;
    end
`else
    if (at_top) begin
      if (loop_s) k_next = k_start_s;
      else        finish = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      K         <= '0;
      P         <= '0;
      k_upd     <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
      k_start_s <= '0;
      k_stop_s  <= '0;
      k_step_s  <= '0;
      dwell_s   <= '0;
      p_s       <= '0;
      loop_s    <= 1'b0;
`ifdef DDS_SWEEP_BIDIR_EN
      bidir_s   <= 1'b0;
      dir_dn    <= 1'b0;
`endif
    end else begin
      k_upd <= 1'b0;
      done  <= 1'b0;
      if (hs) begin
        k_start_s <= cfg_k_start;
        k_stop_s  <= cfg_k_stop;
        k_step_s  <= cfg_k_step;
        dwell_s   <= cfg_dwell;
        p_s       <= cfg_p;
        loop_s    <= cfg_loop;
`ifdef DDS_SWEEP_BIDIR_EN
        bidir_s   <= cfg_bidir;
`endif
      end
      if (state == IDLE) begin
        if (start && !abort) begin
          K     <= st_k;
          P     <= st_p;
          cnt   <= st_d;
          k_upd <= 1'b1;
          state <= DWELL;
`ifdef DDS_SWEEP_BIDIR_EN
          dir_dn <= 1'b0;
`endif
        end
      end else if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          DWELL: begin
            if (cnt == '0) state <= STEP;
            else           cnt   <= cnt - DWELL_W'(1);
          end
          STEP: begin
            if (finish) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              K     <= k_next;
              k_upd <= 1'b1;
              cnt   <= dwell_s;
              state <= DWELL;
`ifdef DDS_SWEEP_BIDIR_EN
              dir_dn <= dir_next;
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed, table-driven bench for dds_sweep_ctrl: sweep sequences, spacing, done timing, abort and reset.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid, cfg_ready;
  logic [31:0] cfg_k_start, cfg_k_stop, cfg_k_step;
  logic [15:0] cfg_dwell;
  logic [10:0] cfg_p;
  logic        cfg_loop;
`ifdef DDS_SWEEP_BIDIR_EN
  logic        cfg_bidir;
`endif
  logic        start, abort;
  logic [31:0] K;
  logic [10:0] P;
  logic        k_upd, busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dds_sweep_ctrl dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_k_start(cfg_k_start), .cfg_k_stop(cfg_k_stop), .cfg_k_step(cfg_k_step),
    .cfg_dwell(cfg_dwell), .cfg_p(cfg_p), .cfg_loop(cfg_loop),
`ifdef DDS_SWEEP_BIDIR_EN
    .cfg_bidir(cfg_bidir),
`endif
    .start(start), .abort(abort),
    .K(K), .P(P), .k_upd(k_upd), .busy(busy), .done(done)
  );

  typedef struct {
    logic [31:0]      ks, kstop, kstep;
    logic [15:0]      d;
    logic [10:0]      p;
    bit               lp;
    bit               bidir;
    int               npts;
    logic [5:0][31:0] exp_k;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] ks, kstop, kstep, input logic [15:0] d,
                              input logic [10:0] p, input bit lp, input bit bidir, input int n,
                              input logic [31:0] e0, e1, e2, e3, e4, e5);
    vec_t r;
    r.ks = ks; r.kstop = kstop; r.kstep = kstep; r.d = d; r.p = p;
    r.lp = lp; r.bidir = bidir; r.npts = n;
    r.exp_k[0] = e0; r.exp_k[1] = e1; r.exp_k[2] = e2;
    r.exp_k[3] = e3; r.exp_k[4] = e4; r.exp_k[5] = e5;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic program_cfg(input vec_t v);
    cfg_valid   = 1'b1;
    cfg_k_start = v.ks;
    cfg_k_stop  = v.kstop;
    cfg_k_step  = v.kstep;
    cfg_dwell   = v.d;
    cfg_p       = v.p;
    cfg_loop    = v.lp;
`ifdef DDS_SWEEP_BIDIR_EN
    cfg_bidir   = v.bidir;
`endif
    chk("cfg_ready_idle", cfg_ready, 1'b1);
    tick();
    cfg_valid = 1'b0;
  endtask

  // Runs one sweep; poke=1 offers a bogus config while the sweep is busy.
  task automatic run(input vec_t v, input bit poke);
    int gap;
    bit seen;
    program_cfg(v);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < v.npts; i++) begin
      if (i > 0) begin
        gap = 0;
        do begin
          tick();
          gap++;
          if (poke && i == 1 && gap == 1) begin
            cfg_valid   = 1'b1;
            cfg_k_start = 32'd1;
            cfg_k_stop  = 32'd5000;
            cfg_dwell   = 16'd9;
            chk("cfg_ready_busy", cfg_ready, 1'b0);
          end else begin
            cfg_valid = 1'b0;
          end
        end while (!k_upd && !done && gap < 100);
        chk("upd_gap", gap, v.d + 2);
      end
      chk("k_upd", k_upd, 1'b1);
      chk("K", K, v.exp_k[i]);
      chk("P", P, v.p);
      chk("busy", busy, 1'b1);
    end
    if (!v.lp) begin
      gap = 0;
      do begin
        tick();
        gap++;
      end while (!k_upd && !done && gap < 100);
      chk("done", done, 1'b1);
      chk("done_gap", gap, v.d + 2);
      chk("K_held", K, v.exp_k[v.npts-1]);
      tick();
      chk("done_pulse", done, 1'b0);
      chk("busy_after", busy, 1'b0);
    end else begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", busy, 1'b0);
      chk("abort_K_held", K, v.exp_k[v.npts-1]);
      chk("abort_ready", cfg_ready, 1'b1);
      chk("abort_no_upd", k_upd, 1'b0);
      seen = 1'b0;
      for (int j = 0; j < 6; j++) begin
        seen |= done;
        tick();
      end
      chk("abort_no_done", seen, 1'b0);
    end
  endtask

  vec_t vecs [6];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = mk(32'd100, 32'd130, 32'd10, 16'd2, 11'd5, 0, 0, 4,
                 32'd100, 32'd110, 32'd120, 32'd130, 32'd0, 32'd0);
    vecs[1] = mk(32'd0, 32'd25, 32'd10, 16'd0, 11'h7FF, 0, 0, 4,
                 32'd0, 32'd10, 32'd20, 32'd25, 32'd0, 32'd0);
    vecs[2] = mk(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd1, 11'd3, 0, 0, 2,
                 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0);
    vecs[3] = mk(32'd50, 32'd40, 32'd7, 16'd1, 11'd9, 0, 0, 1,
                 32'd50, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    vecs[4] = mk(32'd5, 32'd7, 32'd0, 16'd0, 11'd1, 0, 0, 3,
                 32'd5, 32'd6, 32'd7, 32'd0, 32'd0, 32'd0);
    vecs[5] = mk(32'd100, 32'd120, 32'd10, 16'd1, 11'd77, 1, 0, 5,
                 32'd100, 32'd110, 32'd120, 32'd100, 32'd110, 32'd0);

    rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_k_start = '0; cfg_k_stop = '0; cfg_k_step = '0;
    cfg_dwell = '0; cfg_p = '0; cfg_loop = 1'b0;
`ifdef DDS_SWEEP_BIDIR_EN
    cfg_bidir = 1'b0;
`endif
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_K", K, 32'd0);
    chk("rst_P", P, 11'd0);
    chk("rst_k_upd", k_upd, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", cfg_ready, 1'b1);

    for (int i = 0; i < 6; i++) begin
      run(vecs[i], 1'b0);
      tick();
    end

    // Config offered while busy must leave the sweep untouched.
    run(vecs[0], 1'b1);
    tick();

    // start together with abort in IDLE: abort wins, nothing happens.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 1'b0);
    chk("start_abort_upd", k_upd, 1'b0);

    // Reset mid-sweep clears outputs immediately with no done.
    program_cfg(vecs[0]);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("pre_rst_K", K, 32'd110);
    rst = 1'b1;
    #2;
    chk("mid_rst_K", K, 32'd0);
    chk("mid_rst_P", P, 11'd0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_ready", cfg_ready, 1'b1);
    tick();
    rst = 1'b0;
    tick();

`ifdef DDS_SWEEP_BIDIR_EN
    run(mk(32'd10, 32'd30, 32'd10, 16'd1, 11'd2, 0, 1, 5,
           32'd10, 32'd20, 32'd30, 32'd20, 32'd10, 32'd0), 1'b0);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
